// File: rtl/way_select_decoder.sv
// Registered one-hot way-select decoder: hit index or round-robin victim, one output stage.
// Optional INVALID_FIRST_EN: on a miss, allocate the lowest-numbered invalid way before using the pointer.
module way_select_decoder #(
    parameter  int INDEX_WIDTH = 3,
    localparam int WAYS        = 2 ** INDEX_WIDTH
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic                   i_in_hit,
    input  logic [INDEX_WIDTH-1:0] i_in_index,
    input  logic [WAYS-1:0]        i_in_valid_ways,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [WAYS-1:0]        o_out_way,
    output logic [INDEX_WIDTH-1:0] o_out_index,
    output logic                   o_out_miss
);

    logic                   r_out_valid;
    logic [WAYS-1:0]        r_out_way;
    logic [INDEX_WIDTH-1:0] r_out_index;
    logic                   r_out_miss;
    logic [INDEX_WIDTH-1:0] r_ptr;

    logic                   w_in_ready;
    logic                   w_accept;
    logic [INDEX_WIDTH-1:0] w_victim;
    logic                   w_victim_uses_ptr;
    logic [INDEX_WIDTH-1:0] w_sel;
    logic                   w_ptr_adv;

    assign w_in_ready = !i_reset && (!r_out_valid || i_out_ready);
    assign w_accept   = i_in_valid && w_in_ready;

`ifdef INVALID_FIRST_EN
    // Descending scan so the last assignment wins with the lowest invalid way.
    always_comb begin
        w_victim          = r_ptr;
        w_victim_uses_ptr = 1'b1;
        for (int k = WAYS - 1; k >= 0; k--) begin
            if (!i_in_valid_ways[k]) begin
                w_victim          = INDEX_WIDTH'(k);
                w_victim_uses_ptr = 1'b0;
            end
        end
    end
`else
    logic w_unused_valid_ways;
    assign w_unused_valid_ways = ^i_in_valid_ways;
    assign w_victim            = r_ptr;
    assign w_victim_uses_ptr   = 1'b1;
`endif

    assign w_sel     = i_in_hit ? i_in_index : w_victim;
    assign w_ptr_adv = w_accept && !i_in_hit && w_victim_uses_ptr;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out_valid <= 1'b0;
            r_out_way   <= '0;
            r_out_index <= '0;
            r_out_miss  <= 1'b0;
            r_ptr       <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_way   <= WAYS'(1) << w_sel;
                r_out_index <= w_sel;
                r_out_miss  <= !i_in_hit;
            end else if (r_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
            end
            // Pointer wraps naturally at WAYS since it is exactly INDEX_WIDTH bits.
            if (w_ptr_adv) begin
                r_ptr <= r_ptr + INDEX_WIDTH'(1);
            end
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_way   = r_out_way;
    assign o_out_index = r_out_index;
    assign o_out_miss  = r_out_miss;

endmodule

// File: tb/tb_way_select_decoder.sv
// Bench for way_select_decoder: directed scenarios then random traffic against a behavioural model.
// Honours INVALID_FIRST_EN the same way the design does.
module tb_way_select_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic       in_hit;
    logic [2:0] in_index;
    logic [7:0] in_valid_ways;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_way;
    logic [2:0] out_index;
    logic       out_miss;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    bit m_valid;
    int m_index;
    bit m_miss;
    int m_ptr;
    int m_way;
    bit m_ready;

    always #5 clk = ~clk;

    way_select_decoder #(.INDEX_WIDTH(3)) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_in_valid      (in_valid),
        .o_in_ready      (in_ready),
        .i_in_hit        (in_hit),
        .i_in_index      (in_index),
        .i_in_valid_ways (in_valid_ways),
        .o_out_valid     (out_valid),
        .i_out_ready     (out_ready),
        .o_out_way       (out_way),
        .o_out_index     (out_index),
        .o_out_miss      (out_miss)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick_victim(input logic [7:0] vw, output bit used_ptr);
        used_ptr = 1'b1;
`ifdef INVALID_FIRST_EN
        for (int k = 0; k < 8; k++) begin
            if (vw[k] == 1'b0) begin
                used_ptr = 1'b0;
                return k;
            end
        end
`endif
        return m_ptr;
    endfunction

    // One clock cycle: drive, check ready, clock, update model, check outputs.
    task automatic step(input bit rst, input bit v, input bit hit, input int idx,
                        input logic [7:0] vw, input bit ordy);
        int  sel;
        bit  used_ptr;
        reset         = rst;
        in_valid      = v;
        in_hit        = hit;
        in_index      = 3'(idx);
        in_valid_ways = vw;
        out_ready     = ordy;
        #1;
        m_ready = !rst && (!m_valid || ordy);
        chk("in_ready", 32'(in_ready), 32'(m_ready));
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 0; m_index = 0; m_miss = 0; m_ptr = 0; m_way = 0;
        end else if (v && m_ready) begin
            if (hit) sel = idx;
            else begin
                sel = pick_victim(vw, used_ptr);
                if (used_ptr) m_ptr = (m_ptr + 1) % 8;
            end
            m_valid = 1; m_index = sel; m_miss = !hit; m_way = 1 << sel;
        end else if (m_valid && ordy) begin
            m_valid = 0;
        end
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_way",   32'(out_way),   32'(m_way));
        chk("out_index", 32'(out_index), 32'(m_index));
        chk("out_miss",  32'(out_miss),  32'(m_miss));
        if (m_valid) chk("onehot", 32'($countones(out_way)), 32'd1);
    endtask

    initial begin
        m_valid = 0; m_index = 0; m_miss = 0; m_ptr = 0; m_way = 0;
        // Reset state
        step(1, 0, 0, 0, 8'hFF, 1);
        step(1, 1, 0, 0, 8'hFF, 1);
        // Hit decode, then a miss must still see pointer 0
        step(0, 1, 1, 5, 8'hFF, 1);
        chk("hit5_way", 32'(out_way), 32'h20);
        step(0, 1, 0, 6, 8'hFF, 1);
        chk("miss_after_hit", 32'(out_index), 32'd0);
        step(0, 0, 0, 0, 8'hFF, 1);
        // Wrap-around: reset, nine consecutive misses
        step(1, 0, 0, 0, 8'hFF, 1);
        for (int i = 0; i < 9; i++) begin
            step(0, 1, 0, 7, 8'hFF, 1);
            chk("wrap_index", 32'(out_index), 32'(i % 8));
        end
        step(0, 0, 0, 0, 8'hFF, 1);
        // Backpressure: reset, miss, then stall 3 cycles with a second miss pending
        step(1, 0, 0, 0, 8'hFF, 1);
        step(0, 1, 0, 0, 8'hFF, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 8'hFF, 0);
            chk("stall_ready", 32'(in_ready), 32'd0);
            chk("stall_index", 32'(out_index), 32'd0);
        end
        step(0, 1, 0, 0, 8'hFF, 1);
        chk("bp_second", 32'(out_index), 32'd1);
        step(0, 0, 0, 0, 8'hFF, 1);
        // Invalid-first: bring pointer to 3, then miss with 8'b1111_0011
        step(1, 0, 0, 0, 8'hFF, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 8'hFF, 1);
        step(0, 1, 0, 0, 8'hF3, 1);
`ifdef INVALID_FIRST_EN
        chk("invfirst_idx", 32'(out_index), 32'd2);
        chk("invfirst_way", 32'(out_way), 32'h04);
`else
        chk("invfirst_idx", 32'(out_index), 32'd3);
`endif
        step(0, 1, 0, 0, 8'hFF, 1);
`ifdef INVALID_FIRST_EN
        chk("invfirst_ptr", 32'(out_index), 32'd3);
`else
        chk("invfirst_ptr", 32'(out_index), 32'd4);
`endif
        // Reset mid-operation: stalled output, pointer 3
        step(1, 0, 0, 0, 8'hFF, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 8'hFF, 1);
        step(0, 0, 0, 0, 8'hFF, 0);
        step(1, 1, 0, 0, 8'hFF, 0);
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_way", 32'(out_way), 32'd0);
        step(0, 1, 0, 0, 8'hFF, 1);
        chk("rst_mid_next", 32'(out_index), 32'd0);
        // Random traffic
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1),
                 $urandom_range(0, 7),
                 ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom),
                 ($urandom_range(0, 2) != 0));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/way_select_decoder.md
# way_select_decoder

Registered 3-to-8 way-select decoder for the 8-way set-associative cache datapath. It is the inverse of the set's hit encoder:
- On a hit, it turns the encoded hit way back into a one-hot way enable.
- On a miss, it chooses a victim way from a round-robin replacement pointer and emits that way one-hot.

It sits between the tag-compare stage and the data/tag array write enables, with one output register stage and a valid/ready handshake.

## Interface
- INDEX_WIDTH, 3, width of way index; WAYS = 2**INDEX_WIDTH (8 at default)
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- IN_VALID  in  1  request present
- IN_READY  out  1  block can accept a request this cycle
- IN_HIT  in  1  1 = hit (use IN_INDEX), 0 = miss (allocate victim)
- IN_INDEX  in  INDEX_WIDTH  hit way index; ignored when IN_HIT=0
- IN_VALID_WAYS  in  WAYS  valid bits of the addressed set, bit k = way k
- OUT_VALID  out  1  output holds a decoded way
- OUT_READY  in  1  downstream consumes output this cycle
- OUT_WAY  out  WAYS  one-hot way enable, bit k set for way k
- OUT_INDEX  out  INDEX_WIDTH  binary index of the selected way
- OUT_MISS  out  1  registered copy of !IN_HIT for the accepted request

## Operation
- Accept: accept = IN_VALID && IN_READY.
- IN_READY = !RESET && (!OUT_VALID || OUT_READY). This is combinational, one-entry pipeline.
- Way selection on accept:
  - Hit: sel = IN_INDEX.
  - Miss: sel = victim (see Configuration), then PTR advances if the pointer was used.
- PTR: INDEX_WIDTH-bit round-robin pointer. It increments mod WAYS, wrapping 7 to 0. It never changes on a hit, an idle cycle or a stalled cycle.
- Output register on accept:
  - OUT_INDEX <= sel
  - OUT_WAY <= one-hot(sel); exactly one bit is set whenever OUT_VALID=1
  - OUT_MISS <= !IN_HIT
  - OUT_VALID <= 1
- Drain: OUT_VALID && OUT_READY with no accept → OUT_VALID <= 0. OUT_WAY, OUT_INDEX and OUT_MISS keep their last values.
- Round-trip: OUT_WAY passed through the hit encoder returns OUT_INDEX.
- Reset values:
  - OUT_VALID=0, OUT_WAY=0, OUT_INDEX=0, OUT_MISS=0, PTR=0.
  - IN_READY=0 while RESET=1, and 1 in the first cycle after reset.

## Timing
- Latency: 1 cycle. A request accepted at edge N is on the outputs after edge N, with OUT_VALID=1.
- Throughput: 1 request/cycle while OUT_READY=1.
- Simultaneous drain and accept in the same cycle: the new result is loaded and OUT_VALID stays 1 with no bubble.
- Stall: while OUT_VALID=1 and OUT_READY=0, all outputs and PTR are held stable and IN_READY=0.
- Back-to-back misses: each sees the PTR value already advanced by the previous accept.
- Reset mid-operation: a pending output is discarded (OUT_VALID=0) and PTR returns to 0. A request presented during the reset cycle is not accepted.

## Configuration
- INVALID_FIRST_EN defined:
  - A miss with any IN_VALID_WAYS bit at 0 selects the lowest-numbered invalid way, and PTR is not advanced.
  - If all ways are valid, the victim is PTR and PTR advances.
- INVALID_FIRST_EN undefined:
  - IN_VALID_WAYS is ignored.
  - Every miss selects PTR and advances PTR.

## Test plan
- Hit decode: after reset, hit with IN_INDEX=5 → next cycle OUT_VALID=1, OUT_WAY=8'b0010_0000, OUT_INDEX=5, OUT_MISS=0. A following miss selects index 0, proving PTR was untouched.
- Wrap-around: IN_VALID_WAYS=8'hFF, OUT_READY=1, nine consecutive misses → OUT_INDEX 0,1,2,…,7,0 on consecutive cycles with OUT_MISS=1 each.
- Backpressure: miss accepted, then OUT_READY=0 for 3 cycles with a second miss pending:
  - During the stall, IN_READY=0, OUT_INDEX=0 held, PTR=1 held.
  - With OUT_READY=1, the second miss is accepted and shows OUT_INDEX=1 next cycle.
- Invalid-first: PTR=3, miss with IN_VALID_WAYS=8'b1111_0011.
  - With INVALID_FIRST_EN: OUT_INDEX=2, OUT_WAY=8'b0000_0100, PTR stays 3.
  - Without it: OUT_INDEX=3, PTR=4.
- Reset mid-operation: OUT_VALID=1 stalled, PTR=3; RESET high for 1 cycle → OUT_VALID=0, OUT_WAY=0, IN_READY=0 during reset. The next miss yields OUT_INDEX=0.
